// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared encodings for the five-stage MIPS core pipeline registers:
//   - PCSrc, RegDst, MemtoReg and BranchOp codes
//   - REG_RA (link register number)
//   - ctrl_word_t, the packed control word carried by ID/EX and EX/MEM
//   - resolve_dst(), maps RegDst plus instruction fields to a write register
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  localparam logic [1:0] REGDST_RD    = 2'b00;
  localparam logic [1:0] REGDST_RT    = 2'b01;
  localparam logic [1:0] REGDST_RA    = 2'b10;
  localparam logic [1:0] REGDST_RSVD  = 2'b11;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

  localparam logic [2:0] BROP_NONE    = 3'd0;
  localparam logic [2:0] BROP_BEQ     = 3'd1;
  localparam logic [2:0] BROP_BNE     = 3'd2;
  localparam logic [2:0] BROP_BLEZ    = 3'd3;
  localparam logic [2:0] BROP_BGTZ    = 3'd4;

  localparam logic [4:0] REG_RA       = 5'd31;

  typedef struct packed {
    logic [1:0] pcsrc;
    logic       regwrite;
    logic [1:0] regdst;
    logic       memread;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic       alusrc1;
    logic       alusrc2;
    logic [2:0] branchop;
  } ctrl_word_t;

  // The reserved RegDst code writes $0, which the register file discards.
  function automatic logic [4:0] resolve_dst(input logic [1:0] regdst,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
    logic [4:0] dst;
    case (regdst)
      REGDST_RD: dst = rd;
      REGDST_RT: dst = rt;
      REGDST_RA: dst = REG_RA;
      default:   dst = 5'd0;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use and jump-register hazard detection for ID/EX.
// Ports:
//   id_rs, id_rt      in  5  source registers of the instruction in ID
//   id_pcsrc          in  2  PCSrc of the instruction in ID
//   ex_valid          in  1  EX slot holds a real instruction
//   ex_memread        in  1  EX instruction is a load
//   ex_regwrite       in  1  EX instruction writes a register
//   ex_dst            in  5  EX write register
//   flush             in  1  redirect taken in EX
//   stall             out 1  hold PC and IF/ID, bubble into EX
// ---------------------------------------------------------------------------
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_pcsrc,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_dst,
  input  logic       flush,
  output logic       stall
);

  logic load_use;
  logic jr_hazard;

  // rt is compared for every opcode, even when it is only a destination;
  // an occasional spurious stall is cheaper than decoding source usage.
  assign load_use = ex_valid && ex_memread && (ex_dst != 5'd0) &&
                    ((ex_dst == id_rs) || (ex_dst == id_rt));

  // jr reads rs in ID, so any in-flight writer of rs must settle first.
  assign jr_hazard = (id_pcsrc == PCSRC_JR) && ex_valid && ex_regwrite &&
                     (ex_dst != 5'd0) && (ex_dst == id_rs);

  // A redirect kills the ID instruction anyway, so never hold the PC then.
  assign stall = (load_use || jr_hazard) && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the five-stage MIPS core. Latches the decoded
// control word and operands, resolves the write register, and inserts a
// bubble on a hazard stall or an EX redirect.
// Ports:
//   clk, reset            core clock (rising edge), async active-high reset
//   id_<control>          control word from the decoder
//   id_<operands/fields>  PC+4, register data, immediate, rs/rt/rd/shamt/funct
//   flush                 redirect taken in EX, squashes the ID instruction
//   stall                 hold PC and IF/ID this cycle (combinational)
//   ex_*                  registered copies of every id_* input
//   ex_dst                resolved write register
//   ex_valid              EX slot holds a real instruction
//   stall_cycles,
//   flush_cycles          saturating event counters
// Configuration:
//   ID_EX_PERF_CNT_EN     when defined, adds stall_cycles / flush_cycles
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  id_pcsrc,
  input  logic        id_regwrite,
  input  logic [1:0]  id_regdst,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic [1:0]  id_memtoreg,
  input  logic        id_alusrc1,
  input  logic        id_alusrc2,
  input  logic [2:0]  id_branchop,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm_ext,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  input  logic [5:0]  id_funct,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  ex_pcsrc,
  output logic        ex_regwrite,
  output logic [1:0]  ex_regdst,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [1:0]  ex_memtoreg,
  output logic        ex_alusrc1,
  output logic        ex_alusrc2,
  output logic [2:0]  ex_branchop,
  output logic [31:0] ex_pc_plus4,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm_ext,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_shamt,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_dst,
  output logic        ex_valid
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  ctrl_word_t id_ctrl;
  ctrl_word_t ex_ctrl;
  logic       bubble;

  assign id_ctrl = '{pcsrc:    id_pcsrc,
                     regwrite: id_regwrite,
                     regdst:   id_regdst,
                     memread:  id_memread,
                     memwrite: id_memwrite,
                     memtoreg: id_memtoreg,
                     alusrc1:  id_alusrc1,
                     alusrc2:  id_alusrc2,
                     branchop: id_branchop};

  hazard_detect u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_pcsrc    (id_pcsrc),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_ctrl.memread),
    .ex_regwrite (ex_ctrl.regwrite),
    .ex_dst      (ex_dst),
    .flush       (flush),
    .stall       (stall)
  );

  // stall is already masked by flush, so this covers both bubble sources.
  assign bubble = flush || stall;

  // Data fields load on every edge, bubble or not; only the control word,
  // dst and valid are zeroed so a bubble can never write or read memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl     <= '0;
      ex_dst      <= 5'd0;
      ex_valid    <= 1'b0;
      ex_pc_plus4 <= 32'd0;
      ex_rs_data  <= 32'd0;
      ex_rt_data  <= 32'd0;
      ex_imm_ext  <= 32'd0;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      ex_shamt    <= 5'd0;
      ex_funct    <= 6'd0;
    end else begin
      ex_pc_plus4 <= id_pc_plus4;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm_ext  <= id_imm_ext;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_shamt    <= id_shamt;
      ex_funct    <= id_funct;
      if (bubble) begin
        ex_ctrl  <= '0;
        ex_dst   <= 5'd0;
        ex_valid <= 1'b0;
      end else begin
        ex_ctrl  <= id_ctrl;
        ex_dst   <= resolve_dst(id_regdst, id_rt, id_rd);
        ex_valid <= 1'b1;
      end
    end
  end

  assign ex_pcsrc    = ex_ctrl.pcsrc;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_regdst   = ex_ctrl.regdst;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_alusrc1  = ex_ctrl.alusrc1;
  assign ex_alusrc2  = ex_ctrl.alusrc2;
  assign ex_branchop = ex_ctrl.branchop;

`ifdef ID_EX_PERF_CNT_EN
  // Saturating counters; they hold at all-ones until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush && (flush_cycles != 32'hFFFF_FFFF))
        flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: a table of instruction vectors with
// hand-derived expected stall and EX-slot contents, a scoreboard queue of
// expected EX results, plus reset-value and reset-mid-stall sequences.
// Define ID_EX_PERF_CNT_EN to also check the event counters.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  id_pcsrc;
  logic        id_regwrite;
  logic [1:0]  id_regdst;
  logic        id_memread;
  logic        id_memwrite;
  logic [1:0]  id_memtoreg;
  logic        id_alusrc1;
  logic        id_alusrc2;
  logic [2:0]  id_branchop;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm_ext;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic        flush;
  logic        stall;
  logic [1:0]  ex_pcsrc;
  logic        ex_regwrite;
  logic [1:0]  ex_regdst;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [1:0]  ex_memtoreg;
  logic        ex_alusrc1;
  logic        ex_alusrc2;
  logic [2:0]  ex_branchop;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm_ext;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_shamt;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_dst;
  logic        ex_valid;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  id_ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .id_pcsrc    (id_pcsrc),
    .id_regwrite (id_regwrite),
    .id_regdst   (id_regdst),
    .id_memread  (id_memread),
    .id_memwrite (id_memwrite),
    .id_memtoreg (id_memtoreg),
    .id_alusrc1  (id_alusrc1),
    .id_alusrc2  (id_alusrc2),
    .id_branchop (id_branchop),
    .id_pc_plus4 (id_pc_plus4),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .id_imm_ext  (id_imm_ext),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_shamt    (id_shamt),
    .id_funct    (id_funct),
    .flush       (flush),
    .stall       (stall),
    .ex_pcsrc    (ex_pcsrc),
    .ex_regwrite (ex_regwrite),
    .ex_regdst   (ex_regdst),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_memtoreg (ex_memtoreg),
    .ex_alusrc1  (ex_alusrc1),
    .ex_alusrc2  (ex_alusrc2),
    .ex_branchop (ex_branchop),
    .ex_pc_plus4 (ex_pc_plus4),
    .ex_rs_data  (ex_rs_data),
    .ex_rt_data  (ex_rt_data),
    .ex_imm_ext  (ex_imm_ext),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .ex_shamt    (ex_shamt),
    .ex_funct    (ex_funct),
    .ex_dst      (ex_dst),
    .ex_valid    (ex_valid)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction presented in ID, with the hand-derived expectations.
  typedef struct {
    logic [1:0] pcsrc;
    logic       regwrite;
    logic [1:0] regdst;
    logic       memread;
    logic [1:0] memtoreg;
    logic [2:0] branchop;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       flush;
    logic       eStall;
    logic       eValid;
    logic       eRegwrite;
    logic       eMemread;
    logic [4:0] eDst;
    logic [1:0] ePcsrc;
    logic [1:0] eMemtoreg;
    logic [2:0] eBranchop;
  } vec_t;

  // Expected EX-slot contents, queued when ID is driven.
  typedef struct {
    int          idx;
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  dst;
    logic [1:0]  pcsrc;
    logic [1:0]  memtoreg;
    logic [2:0]  branchop;
    logic [31:0] pc;
    logic [31:0] rsData;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } exp_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];
  exp_t scoreboard [$];

  function automatic vec_t mk(
      input logic [1:0] pcsrc, input logic rw, input logic [1:0] rdst,
      input logic mr, input logic [1:0] mt, input logic [2:0] bop,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic fl, input logic eStall, input logic eValid,
      input logic eRw, input logic eMr, input logic [4:0] eDst,
      input logic [1:0] ePc, input logic [1:0] eMt, input logic [2:0] eBop);
    vec_t v;
    v.pcsrc = pcsrc; v.regwrite = rw; v.regdst = rdst; v.memread = mr;
    v.memtoreg = mt; v.branchop = bop; v.rs = rs; v.rt = rt; v.rd = rd;
    v.flush = fl; v.eStall = eStall; v.eValid = eValid; v.eRegwrite = eRw;
    v.eMemread = eMr; v.eDst = eDst; v.ePcsrc = ePc; v.eMemtoreg = eMt;
    v.eBranchop = eBop;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives instruction idx onto the ID inputs; data fields are derived from
  // the index so their pass-through can be checked too.
  task automatic applyStimulus(input vec_t v, input int idx);
    id_pcsrc    = v.pcsrc;
    id_regwrite = v.regwrite;
    id_regdst   = v.regdst;
    id_memread  = v.memread;
    id_memwrite = (idx == 18 || idx == 19);
    id_memtoreg = v.memtoreg;
    id_alusrc1  = idx[0];
    id_alusrc2  = idx[1];
    id_branchop = v.branchop;
    id_pc_plus4 = 32'h0000_0400 + 32'(idx) * 4;
    id_rs_data  = 32'hA000_0000 + 32'(idx);
    id_rt_data  = 32'hB000_0000 + 32'(idx);
    id_imm_ext  = 32'hFFFF_0000 | 32'(idx);
    id_rs       = v.rs;
    id_rt       = v.rt;
    id_rd       = v.rd;
    id_shamt    = 5'(idx);
    id_funct    = 6'h20 + 6'(idx);
    flush       = v.flush;
  endtask

  task automatic checkEx(input exp_t e);
    string p;
    p = $sformatf("v%0d", e.idx);
    checkOutput({p, ".ex_valid"},    32'(ex_valid),    32'(e.valid));
    checkOutput({p, ".ex_regwrite"}, 32'(ex_regwrite), 32'(e.regwrite));
    checkOutput({p, ".ex_memread"},  32'(ex_memread),  32'(e.memread));
    checkOutput({p, ".ex_memwrite"}, 32'(ex_memwrite), 32'(e.memwrite));
    checkOutput({p, ".ex_dst"},      32'(ex_dst),      32'(e.dst));
    checkOutput({p, ".ex_pcsrc"},    32'(ex_pcsrc),    32'(e.pcsrc));
    checkOutput({p, ".ex_memtoreg"}, 32'(ex_memtoreg), 32'(e.memtoreg));
    checkOutput({p, ".ex_branchop"}, 32'(ex_branchop), 32'(e.branchop));
    checkOutput({p, ".ex_pc_plus4"}, ex_pc_plus4,      e.pc);
    checkOutput({p, ".ex_rs_data"},  ex_rs_data,       e.rsData);
    checkOutput({p, ".ex_rs"},       32'(ex_rs),       32'(e.rs));
    checkOutput({p, ".ex_rt"},       32'(ex_rt),       32'(e.rt));
  endtask

  task automatic checkAllZero(input string p);
    checkOutput({p, ".ex_valid"},    32'(ex_valid),    32'd0);
    checkOutput({p, ".ex_regwrite"}, 32'(ex_regwrite), 32'd0);
    checkOutput({p, ".ex_memread"},  32'(ex_memread),  32'd0);
    checkOutput({p, ".ex_dst"},      32'(ex_dst),      32'd0);
    checkOutput({p, ".ex_pcsrc"},    32'(ex_pcsrc),    32'd0);
    checkOutput({p, ".ex_pc_plus4"}, ex_pc_plus4,      32'd0);
    checkOutput({p, ".ex_rs_data"},  ex_rs_data,       32'd0);
    checkOutput({p, ".ex_funct"},    32'(ex_funct),    32'd0);
    checkOutput({p, ".stall"},       32'(stall),       32'd0);
  endtask

  initial begin
    exp_t e;
    int   expStalls;
    int   expFlushes;
    expStalls  = 0;
    expFlushes = 0;

    //          pc rw rd mr mt bop rs  rt  rd  fl | st  v rw mr dst pc mt bop
    vecs[0]  = mk(0, 1, 1, 1, 1, 0,  2,  8,  0, 0,   0, 1, 1, 1,  8, 0, 1, 0); // lw $8
    vecs[1]  = mk(0, 1, 0, 0, 0, 0,  8,  3,  9, 0,   1, 0, 0, 0,  0, 0, 0, 0); // add uses $8
    vecs[2]  = mk(0, 1, 0, 0, 0, 0,  8,  3,  9, 0,   0, 1, 1, 0,  9, 0, 0, 0); // add retried
    vecs[3]  = mk(0, 1, 1, 1, 1, 0,  4,  0,  0, 0,   0, 1, 1, 1,  0, 0, 1, 0); // lw $0
    vecs[4]  = mk(0, 1, 0, 0, 0, 0,  0,  0, 10, 0,   0, 1, 1, 0, 10, 0, 0, 0); // uses $0
    vecs[5]  = mk(0, 1, 1, 0, 0, 0, 10, 31,  0, 0,   0, 1, 1, 0, 31, 0, 0, 0); // addi $31
    vecs[6]  = mk(3, 0, 0, 0, 0, 0, 31,  0,  0, 0,   1, 0, 0, 0,  0, 0, 0, 0); // jr $31
    vecs[7]  = mk(3, 0, 0, 0, 0, 0, 31,  0,  0, 0,   0, 1, 0, 0,  0, 3, 0, 0); // jr retried
    vecs[8]  = mk(0, 1, 1, 1, 1, 0,  0,  5,  0, 0,   0, 1, 1, 1,  5, 0, 1, 0); // lw $5
    vecs[9]  = mk(0, 1, 0, 0, 0, 0,  5,  1,  6, 1,   0, 0, 0, 0,  0, 0, 0, 0); // dep + flush
    vecs[10] = mk(2, 1, 2, 0, 2, 0,  0,  0,  0, 0,   0, 1, 1, 0, 31, 2, 2, 0); // jal
    vecs[11] = mk(0, 1, 3, 0, 0, 0,  7,  7,  7, 0,   0, 1, 1, 0,  0, 0, 0, 0); // RegDst 11
    vecs[12] = mk(0, 1, 1, 1, 1, 0,  0, 31,  0, 0,   0, 1, 1, 1, 31, 0, 1, 0); // lw $31
    vecs[13] = mk(3, 0, 0, 0, 0, 0, 31,  0,  0, 0,   1, 0, 0, 0,  0, 0, 0, 0); // jr behind lw
    vecs[14] = mk(3, 0, 0, 0, 0, 0, 31,  0,  0, 0,   0, 1, 0, 0,  0, 3, 0, 0); // jr retried
    vecs[15] = mk(1, 0, 0, 0, 0, 1, 31, 31,  0, 1,   0, 0, 0, 0,  0, 0, 0, 0); // beq flushed
    vecs[16] = mk(1, 0, 0, 0, 0, 1,  3,  4,  0, 0,   0, 1, 0, 0,  0, 1, 0, 1); // beq
    vecs[17] = mk(0, 1, 1, 1, 1, 0,  3, 12,  0, 0,   0, 1, 1, 1, 12, 0, 1, 0); // lw $12
    vecs[18] = mk(0, 0, 0, 0, 0, 0,  1, 12,  0, 0,   1, 0, 0, 0,  0, 0, 0, 0); // sw via rt
    vecs[19] = mk(0, 0, 0, 0, 0, 0,  1, 12,  0, 0,   0, 1, 0, 0,  0, 0, 0, 0); // sw retried

    reset = 1'b1;
    applyStimulus(vecs[0], 0);
    flush = 1'b0;
    #1;
    checkAllZero("reset");

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
      #1;
      checkOutput($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].eStall));
      if (vecs[i].eStall) expStalls++;
      if (vecs[i].flush)  expFlushes++;

      e.idx      = i;
      e.valid    = vecs[i].eValid;
      e.regwrite = vecs[i].eRegwrite;
      e.memread  = vecs[i].eMemread;
      e.memwrite = vecs[i].eValid && (i == 18 || i == 19);
      e.dst      = vecs[i].eDst;
      e.pcsrc    = vecs[i].ePcsrc;
      e.memtoreg = vecs[i].eMemtoreg;
      e.branchop = vecs[i].eBranchop;
      e.pc       = 32'h0000_0400 + 32'(i) * 4;
      e.rsData   = 32'hA000_0000 + 32'(i);
      e.rs       = vecs[i].rs;
      e.rt       = vecs[i].rt;
      scoreboard.push_back(e);

      @(posedge clk);
      #1;
      if (scoreboard.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL scoreboard: got empty queue, expected entry %0d", i);
      end else begin
        checkEx(scoreboard.pop_front());
      end
      @(negedge clk);
    end

`ifdef ID_EX_PERF_CNT_EN
    checkOutput("stall_cycles", stall_cycles, 32'(expStalls));
    checkOutput("flush_cycles", flush_cycles, 32'(expFlushes));
`endif

    // Reset mid-stall: lw $8 into EX, then a dependent add held in ID.
    applyStimulus(vecs[0], 0);
    @(posedge clk);
    #1;
    checkOutput("rst_seq.lw_dst", 32'(ex_dst), 32'd8);
    @(negedge clk);
    applyStimulus(vecs[1], 1);
    #1;
    checkOutput("rst_seq.stall_before", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    checkAllZero("rst_mid_stall");
`ifdef ID_EX_PERF_CNT_EN
    checkOutput("rst_seq.stall_cycles", stall_cycles, 32'd0);
    checkOutput("rst_seq.flush_cycles", flush_cycles, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_seq.stall_after", 32'(stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the five-stage MIPS core. Latches the decoded control word and ID-stage operands into EX, resolves the destination register number, and detects load-use and jump-register hazards. On a hazard it raises a one-cycle stall to the PC and IF/ID register and inserts a bubble. On an EX-resolved redirect it squashes the ID instruction.

## Interface
Parameters:
- none; widths fixed by the 32-bit ISA.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- id_pcsrc / id_regwrite / id_regdst / id_memread / id_memwrite / id_memtoreg / id_alusrc1 / id_alusrc2 / id_branchop  in  2/1/2/1/1/2/1/1/3  control word from the decoder
- id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext  in  32 each  ID operands
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields
- id_funct  in  6  function field
- flush  in  1  redirect taken in EX (branch taken, or jump from ID/EX)
- stall  out  1  hold PC and IF/ID this cycle
- ex_* (one per id_* input above)  out  same widths  registered copies
- ex_dst  out  5  resolved write register
- ex_valid  out  1  EX slot holds a real instruction
- stall_cycles, flush_cycles  out  32 each  present only with ID_EX_PERF_CNT_EN

## Operation
- ex_dst encoding: RegDst 00 selects rd, 01 selects rt, 10 selects 31; 11 is reserved and selects 0. The value is computed from ID fields and registered with the word.
- Load-use hazard: ex_valid && ex_memread && ex_dst != 0 && (ex_dst == id_rs || ex_dst == id_rt). Comparison is conservative for all opcodes.
- Jump-register hazard: id_pcsrc == 11 && ex_valid && ex_regwrite && ex_dst != 0 && ex_dst == id_rs.
- stall = (load-use || jr hazard) && !flush. stall is combinational from the ID inputs and the registered EX state.
- Each rising edge, priority order:
  - reset: asynchronous clear.
  - flush: load bubble.
  - stall: load bubble.
  - otherwise: load the ID word and set ex_valid = 1.
- Bubble definition:
  - all control outputs 0, ex_dst = 0, ex_valid = 0.
  - Data outputs (pc, rs/rt data, imm, fields) still load from ID; they are don't-care but deterministic.
- flush has priority over stall. Stall is suppressed during flush, so the PC redirect proceeds.
- A bubble has memread = 0 and regwrite = 0. A load-use stall therefore lasts exactly one cycle.
- A jr hazard behind an ALU op lasts one cycle. A jr behind lw stalls one cycle; the following cycle re-evaluates against the bubble and proceeds. jr forwarding from MEM is handled downstream.

## Timing
- Latency: ID to EX outputs is 1 cycle. stall is 0-cycle combinational.
- Reset values: every ex_* output 0, ex_valid 0, ex_dst 0, counters 0. stall is 0 while reset is asserted.
- Reset mid-stall: state clears asynchronously; stall drops in the same cycle.
- flush and stall in the same cycle: bubble is loaded, stall = 0, stall_cycles not incremented, flush_cycles incremented.

## Configuration
- ID_EX_PERF_CNT_EN defined:
  - stall_cycles increments on each cycle with stall = 1.
  - flush_cycles increments on each cycle with flush = 1.
  - Both saturate at 0xFFFFFFFF and clear only on reset.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package: PCSrc encodings (00 seq, 01 branch, 10 jump, 11 jr), RegDst encodings, MemtoReg encodings, BranchOp codes 0–4, REG_RA = 31, and the packed control-word typedef used by ID/EX and EX/MEM.
- Sub-module hazard_detect: combinational. Takes id_rs, id_rt, id_pcsrc, ex_valid, ex_memread, ex_regwrite, ex_dst, flush; produces stall.

## Test plan
- lw $8 in EX (ex_dst = 8), add with rs = 8 in ID -> stall = 1 for one cycle, next ex_valid = 0, then add enters EX with ex_regwrite = 1, ex_dst = rd.
- lw $0 in EX, dependent instruction in ID -> no stall.
- addi $31 in EX, jr $31 in ID -> stall = 1 for one cycle; next cycle stall = 0 and jr latches with ex_pcsrc = 11.
- lw $5 in EX with flush = 1 and rs = 5 in ID -> stall = 0, bubble loaded, flush_cycles += 1.
- jal in ID -> ex_dst = 31, ex_memtoreg = 10; RegDst = 11 -> ex_dst = 0.
- Assert reset mid-stall -> all outputs 0 immediately. With ID_EX_PERF_CNT_EN and stall_cycles preset to 0xFFFFFFFF, a further stall -> counter stays 0xFFFFFFFF.
